// File: rtl/hwjsoc_cpu_f_ocimem_seq_if.sv
// Debug RAM master bus (Avalon-style) between the OCI memory sequencer
// and the on-chip debug RAM.
interface hwjsoc_cpu_f_ocimem_seq_if;
    logic [8:0]  ram_addr;
    logic        ram_rd;
    logic        ram_wr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_waitrequest;

    modport master (
        output ram_addr,
        output ram_rd,
        output ram_wr,
        output ram_wdata,
        input  ram_rdata,
        input  ram_waitrequest
    );

    modport slave (
        input  ram_addr,
        input  ram_rd,
        input  ram_wr,
        input  ram_wdata,
        output ram_rdata,
        output ram_waitrequest
    );
endinterface

// File: rtl/hwjsoc_cpu_f_ocimem_seq.sv
// OCI memory sequencer: turns JTAG debug strobes into single read/write
// accesses on the debug RAM bus, with optional address auto-increment and
// a wait-request timeout that aborts a stuck access.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a debug strobe; bus idle
// RD      | read in flight, ram_rd held until waitrequest drops or timeout
// WR      | write in flight, ram_wr held until waitrequest drops or timeout
// DONE    | one-cycle completion slot; raises monitor_ready on exit
module hwjsoc_cpu_f_ocimem_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [37:0]                    jdo,
    input  logic                           take_action_ocimem_a,
    input  logic                           take_action_ocimem_b,
    input  logic                           take_no_action_ocimem_a,
    hwjsoc_cpu_f_ocimem_seq_if.master      ram,
    output logic [31:0]                    MonDReg,
    output logic                           monitor_ready,
    output logic                           monitor_error
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]  state;
    logic [8:0]  addr;
    logic        autoinc;
    logic [31:0] wdata;
    logic [7:0]  wait_cnt;
    logic        rd_q;
    logic        wr_q;

    // Address and write data are held registers, so the bus sees them
    // stable for the whole access.
    assign ram.ram_addr  = addr;
    assign ram.ram_wdata = wdata;
    assign ram.ram_rd    = rd_q;
    assign ram.ram_wr    = wr_q;

    // Sequencer: strobe decode in IDLE, access/timeout tracking in RD/WR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            autoinc       <= 1'b0;
            wdata         <= '0;
            wait_cnt      <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_action_ocimem_b) begin
                        wdata         <= jdo[34:3];
                        state         <= ST_WR;
                        wr_q          <= 1'b1;
                        wait_cnt      <= '0;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                    end else if (take_action_ocimem_a) begin
                        addr    <= jdo[8:0];
                        autoinc <= jdo[16];
                        // jdo[17] chains an immediate read at the new address.
                        if (jdo[17]) begin
                            state         <= ST_RD;
                            rd_q          <= 1'b1;
                            wait_cnt      <= '0;
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        state         <= ST_RD;
                        rd_q          <= 1'b1;
                        wait_cnt      <= '0;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                    end
                end
                ST_RD, ST_WR: begin
                    if (!ram.ram_waitrequest) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        // Writes echo their data so the host can confirm them.
                        MonDReg <= (state == ST_RD) ? ram.ram_rdata : wdata;
                        if (autoinc) begin
                            addr <= addr + 9'd1;
                        end
                        state   <= ST_DONE;
                    end else if (wait_cnt == TIMEOUT_C) begin
                        // TIMEOUT wait cycles already tolerated: give up.
                        rd_q          <= 1'b0;
                        wr_q          <= 1'b0;
                        monitor_error <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    monitor_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
